// File: rtl/seg_scan_multi_if.sv
// seg_scan_multi_if: datapath-side bundle of the multiplexed seven-segment driver.
//   Load, Disp_Data, Dp_Pos, Blank_Lz : value and display options from the datapath
//   Busy, Ovf                         : conversion status and overflow indication
//   SEL, SEG                          : active-low digit enables and segments to the board
// The master modport is the datapath/bench side; the slave modport is the driver.
interface seg_scan_multi_if #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DATA_W = 16
);
    logic              Load;
    logic [DATA_W-1:0] Disp_Data;
    logic [3:0]        Dp_Pos;
    logic              Blank_Lz;
    logic              Busy;
    logic              Ovf;
    logic [DIGITS-1:0] SEL;
    logic [7:0]        SEG;

    modport master (
        output Load, Disp_Data, Dp_Pos, Blank_Lz,
        input  Busy, Ovf, SEL, SEG
    );

    modport slave (
        input  Load, Disp_Data, Dp_Pos, Blank_Lz,
        output Busy, Ovf, SEL, SEG
    );
endinterface

// File: rtl/seg_scan_multi.sv
// seg_scan_multi: multiplexed common-anode seven-segment driver.
// A binary value captured on Load is converted to BCD by a sequential
// shift-add-3 engine (one step per clock), committed atomically to a display
// register, and scanned across DIGITS digits with leading-zero blanking,
// a programmable decimal point and overflow dashes.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : seg_scan_multi_if slave (Load/Disp_Data/Dp_Pos/Blank_Lz in,
//                Busy/Ovf/SEL/SEG out)
module seg_scan_multi #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic              Clk,
    input  logic              Reset,
    seg_scan_multi_if.slave   bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned STEP_W = $clog2(DATA_W + 1);
    localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
    localparam int unsigned SH_W   = BCD_W + DATA_W;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    // Smallest value that no longer fits in DIGITS decimal digits.
    localparam logic [63:0] OVF_LIMIT    = pow10(DIGITS);
    localparam logic [63:0] DATA_MAX     = (64'd1 << DATA_W) - 64'd1;
    localparam bit          OVF_POSSIBLE = (DATA_MAX >= OVF_LIMIT);

    typedef enum logic {IDLE, CONV} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [3:0]          hold_dp_q, hold_dp_d;
    logic                hold_blz_q, hold_blz_d;
    logic                hold_ovf_q, hold_ovf_d;
    logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
    logic [3:0]          disp_dp_q, disp_dp_d;
    logic                disp_blz_q, disp_blz_d;
    logic                disp_ovf_q, disp_ovf_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [SH_W-1:0]     shifted;
    logic [3:0]          cur_nib;
    logic                upper_zero;
    logic                dp_active;
    logic                blank;
    logic [6:0]          glyph;

    // Conversion FSM: capture on Load, DATA_W double-dabble steps, commit on the last.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        hold_dp_d  = hold_dp_q;
        hold_blz_d = hold_blz_q;
        hold_ovf_d = hold_ovf_q;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        disp_blz_d = disp_blz_q;
        disp_ovf_d = disp_ovf_q;
        bcd_adj    = '0;

        for (int i = 0; i < int'(DIGITS); i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
        shifted = {bcd_adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    state_d    = CONV;
                    bin_d      = bus.Disp_Data;
                    bcd_d      = '0;
                    step_d     = '0;
                    hold_dp_d  = bus.Dp_Pos;
                    hold_blz_d = bus.Blank_Lz;
                    hold_ovf_d = OVF_POSSIBLE && (64'(bus.Disp_Data) >= OVF_LIMIT);
                end
            end
            CONV: begin
                bin_d  = shifted[DATA_W-1:0];
                bcd_d  = shifted[DATA_W +: BCD_W];
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(DATA_W - 1)) begin
                    state_d    = IDLE;
                    disp_bcd_d = shifted[DATA_W +: BCD_W];
                    disp_dp_d  = hold_dp_q;
                    disp_blz_d = hold_blz_q;
                    disp_ovf_d = hold_ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan prescaler/index and the registered SEL/SEG image of the current digit.
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        cur_nib    = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == idx_q) cur_nib = disp_bcd_q[4*i +: 4];
            if (IDX_W'(i) >= idx_q && disp_bcd_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end

        // Zeros at or right of the point are significant and never blanked.
        dp_active = (disp_dp_q < 4'(DIGITS));
        blank     = disp_blz_q && (idx_q != '0) && upper_zero &&
                    (!dp_active || (4'(idx_q) > disp_dp_q));

        case (cur_nib)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase

        if (disp_ovf_q) begin
            seg_d = 8'b1011_1111;
        end else begin
            seg_d = {(4'(idx_q) == disp_dp_q) ? 1'b0 : 1'b1,
                     blank ? 7'b1111111 : glyph};
        end
        sel_d = ~(DIGITS'(1) << idx_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            hold_dp_q  <= 4'hF;
            hold_blz_q <= 1'b1;
            hold_ovf_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_dp_q  <= 4'hF;
            disp_blz_q <= 1'b1;
            disp_ovf_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            sel_q      <= '1;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            hold_dp_q  <= hold_dp_d;
            hold_blz_q <= hold_blz_d;
            hold_ovf_q <= hold_ovf_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            disp_blz_q <= disp_blz_d;
            disp_ovf_q <= disp_ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.Busy = (state_q == CONV);
    assign bus.Ovf  = disp_ovf_q;
    assign bus.SEL  = sel_q;
    assign bus.SEG  = seg_q;
endmodule
